// File: rtl/uart_word_tx_if.sv
// Word-side handshake between an upstream producer and uart_word_tx.
// Latency: none, this is wiring only.
// Backpressure: the producer holds word_valid/word_data until word_ready is seen high.
interface uart_word_tx_if;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;

  // Producer side (FSM, FIFO or bench)
  modport master (
    output word_valid,
    output word_data,
    input  word_ready
  );

  // Transmitter side
  modport slave (
    input  word_valid,
    input  word_data,
    output word_ready
  );
endinterface

// File: rtl/uart_word_tx.sv
// Serialises 32-bit words as four 8N1 (or 8N2) UART bytes, least-significant byte first.
// Latency: the start bit is driven on the acceptance edge; one word takes 4*(9+STOP_BITS) bit times.
// Backpressure: word_ready is high only in IDLE; valid without ready is ignored and data is never re-sampled mid-word.
module uart_word_tx #(
  parameter int CLK_HZ    = 50000000,
  parameter int BIT_RATE  = 9600,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_word_tx_if.slave   word_if,
  output logic            uart_txd,
  output logic            uart_tx_busy,
  output logic            byte_done,
  output logic            word_done
);

  // Truncating division: the small rate error this leaves is tolerated by 8N1 receivers.
  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  // Only 1 or 2 stop bits are meaningful, so a single bit tracks which one is on the line.
  localparam logic STOP_LAST = (STOP_BITS > 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [31:0]      shreg;     // remaining bits of the word, next bit to send at [0]
  logic [CNT_W-1:0] cnt;       // cycles spent in the current bit
  logic [2:0]       bit_idx;   // data bit within the byte
  logic [1:0]       byte_idx;  // byte within the word
  logic             stop_idx;  // which stop bit is on the line
  logic             bit_end;

  // The current bit period finishes on this edge.
  assign bit_end = (cnt == CNT_LAST);

  // Single FSM: every output is registered from the next-state decision so the line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      shreg              <= '0;
      cnt                <= '0;
      bit_idx            <= '0;
      byte_idx           <= '0;
      stop_idx           <= 1'b0;
      uart_txd           <= 1'b1;
      word_if.word_ready <= 1'b0;
      uart_tx_busy       <= 1'b0;
      byte_done          <= 1'b0;
      word_done          <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      word_done <= 1'b0;

      case (state)
        IDLE: begin
          cnt      <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          if (word_if.word_valid && word_if.word_ready) begin
            // Accept: the start bit goes out on this very edge.
            shreg              <= word_if.word_data;
            byte_idx           <= '0;
            state              <= START;
            uart_txd           <= 1'b0;
            word_if.word_ready <= 1'b0;
            uart_tx_busy       <= 1'b1;
          end else begin
            uart_txd           <= 1'b1;
            word_if.word_ready <= 1'b1;
            uart_tx_busy       <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            cnt      <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            uart_txd <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            // Shifting after every data bit leaves the next byte's LSB at shreg[0].
            shreg <= {1'b0, shreg[31:1]};
            if (bit_idx == 3'd7) begin
              stop_idx <= 1'b0;
              state    <= STOP;
              uart_txd <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              uart_txd <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (stop_idx != STOP_LAST) begin
              stop_idx <= 1'b1;
            end else begin
              byte_done <= 1'b1;
              stop_idx  <= 1'b0;
              if (byte_idx != 2'd3) begin
                // Next byte starts immediately, no idle gap inside a word.
                byte_idx <= byte_idx + 2'd1;
                state    <= START;
                uart_txd <= 1'b0;
              end else begin
                word_done          <= 1'b1;
                state              <= IDLE;
                uart_txd           <= 1'b1;
                word_if.word_ready <= 1'b1;
                uart_tx_busy       <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: vector table, hand-written corner sequences and random words.
// Latency: expected line levels are derived from frame arithmetic relative to the acceptance edge.
// Backpressure: the driver waits for word_ready with a bounded loop before presenting a word.
module tb_uart_word_tx;

  localparam int CLK_HZ   = 1000;
  localparam int BIT_RATE = 100;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int S1       = 1;
  localparam int S2       = 2;
  localparam int BYTE1    = (9 + S1) * CPB;
  localparam int WORD1    = 4 * BYTE1;
  localparam int WORD2    = 4 * (9 + S2) * CPB;

  logic clk = 1'b0;
  logic rst;
  logic txd1, busy1, bd1, wd1;
  logic txd2, busy2, bd2, wd2;

  uart_word_tx_if bus1 ();
  uart_word_tx_if bus2 ();

  always #5 clk = ~clk;

  uart_word_tx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .STOP_BITS(S1)) dut1 (
    .clk(clk), .rst(rst), .word_if(bus1),
    .uart_txd(txd1), .uart_tx_busy(busy1), .byte_done(bd1), .word_done(wd1)
  );

  uart_word_tx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .STOP_BITS(S2)) dut2 (
    .clk(clk), .rst(rst), .word_if(bus2),
    .uart_txd(txd2), .uart_tx_busy(busy2), .byte_done(bd2), .word_done(wd2)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected line level k cycles after the acceptance edge, from the frame layout alone.
  function automatic logic line_bit(input logic [31:0] w, input int k, input int stops);
    int frame;
    int b;
    int pos;
    frame = (9 + stops) * CPB;
    b     = k / frame;
    pos   = (k % frame) / CPB;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return w[8*b + pos - 1];
    return 1'b1;
  endfunction

  // ---------------- reference monitor for dut1 ----------------
  logic [31:0] exp_q [$];
  logic [31:0] rx_q  [$];
  int   cyc = 0;
  bit   active = 0;
  bit   pend = 0;
  int   k, pos;
  logic [31:0] cur_w, acc_w, rx_w;
  int   wave_err, pulse_err, hs_err;
  int   stray = 0;
  int   rst_errs = 0;
  int   last_done_cyc = -100;
  int   gap = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      active = 0;
      pend   = 0;
      if (txd1 !== 1'b1 || bus1.word_ready !== 1'b0 || busy1 !== 1'b0 || bd1 !== 1'b0 || wd1 !== 1'b0)
        rst_errs++;
    end else begin
      if (pend) begin
        active = 1; pend = 0; k = 0; cur_w = acc_w; rx_w = '0;
        wave_err = 0; pulse_err = 0; hs_err = 0;
        gap = cyc - last_done_cyc;
      end
      if (active) begin
        if (txd1 !== ((k < WORD1) ? line_bit(cur_w, k, S1) : 1'b1)) wave_err++;
        if (bd1 !== (k > 0 && k % BYTE1 == 0)) pulse_err++;
        if (wd1 !== (k == WORD1)) pulse_err++;
        if (bus1.word_ready !== (k == WORD1) || busy1 !== (k < WORD1)) hs_err++;
        if (k < WORD1 && k % CPB == CPB / 2) begin
          pos = (k % BYTE1) / CPB;
          if (pos >= 1 && pos <= 8) rx_w[8*(k / BYTE1) + pos - 1] = txd1;
        end
        if (k == WORD1) begin
          chk("line_waveform_errs", wave_err, 0);
          chk("done_pulse_errs", pulse_err, 0);
          chk("ready_busy_errs", hs_err, 0);
          rx_q.push_back(rx_w);
          last_done_cyc = cyc;
          active = 0;
        end else begin
          k++;
        end
      end else if (bd1 || wd1) begin
        stray++;
      end
      if (bus1.word_valid && bus1.word_ready) begin
        pend  = 1;
        acc_w = bus1.word_data;
        chk("accept_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("accept_word", acc_w, exp_q.pop_front());
      end
    end
  end

  // ---------------- line receiver for dut2 (loopback style) ----------------
  logic [7:0] exp2_q [$];
  logic [7:0] rx2_q  [$];
  int frame_err2 = 0;

  initial begin : rx2_proc
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    b    = '0;
    forever begin
      @(negedge clk);
      if (!rst && prev && !txd2) begin
        repeat (CPB / 2) @(negedge clk);
        if (txd2 !== 1'b0) frame_err2++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd2;
        end
        for (int i = 0; i < S2; i++) begin
          repeat (CPB) @(negedge clk);
          if (txd2 !== 1'b1) frame_err2++;
        end
        rx2_q.push_back(b);
      end
      prev = rst ? 1'b1 : txd2;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input int which, input logic [31:0] w);
    int n;
    n = 0;
    while (((which == 1) ? bus1.word_ready : bus2.word_ready) !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait_in_budget", 32'(n < 2000), 1);
    if (which == 1) begin
      exp_q.push_back(w);
      bus1.word_data  = w;
      bus1.word_valid = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) exp2_q.push_back(w[8*i +: 8]);
      bus2.word_data  = w;
      bus2.word_valid = 1'b1;
    end
    @(posedge clk); #1;
    if (which == 1) bus1.word_valid = 1'b0;
    else            bus2.word_valid = 1'b0;
  endtask

  // n = cycles from the first post-acceptance cycle to word_done; nbd = byte_done pulses seen.
  task automatic wait_done(input int which, output int n, output int nbd);
    logic d;
    logic b;
    n = 0;
    nbd = 0;
    while (n < 3000) begin
      @(negedge clk);
      d = (which == 1) ? wd1 : wd2;
      b = (which == 1) ? bd1 : bd2;
      if (b) nbd++;
      if (d) break;
      n++;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b [4];
  } vec_t;

  vec_t vecs [7];

  task automatic set_vec(input int i, input logic [31:0] w,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    vecs[i].word = w;
    vecs[i].b[0] = b0;
    vecs[i].b[1] = b1;
    vecs[i].b[2] = b2;
    vecs[i].b[3] = b3;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, nb;
    logic [31:0] rx, w;

    set_vec(0, 32'hfe010113, 8'h13, 8'h01, 8'h01, 8'hfe);
    set_vec(1, 32'h00812e23, 8'h23, 8'h2e, 8'h81, 8'h00);
    set_vec(2, 32'h02010413, 8'h13, 8'h04, 8'h01, 8'h02);
    set_vec(3, 32'hffd00793, 8'h93, 8'h07, 8'hd0, 8'hff);
    set_vec(4, 32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(5, 32'hffffffff, 8'hff, 8'hff, 8'hff, 8'hff);
    set_vec(6, 32'ha5c30f81, 8'h81, 8'h0f, 8'hc3, 8'ha5);

    // Reset held with valid asserted: nothing may be accepted.
    rst = 1'b1;
    bus1.word_valid = 1'b1; bus1.word_data = 32'hdeadbeef;
    bus2.word_valid = 1'b1; bus2.word_data = 32'h12345678;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd1), 1);
    chk("rst_ready", 32'(bus1.word_ready), 0);
    chk("rst_busy", 32'(busy1), 0);
    rst = 1'b0;
    bus1.word_valid = 1'b0;
    bus2.word_valid = 1'b0;
    chk("ready_at_release", 32'(bus1.word_ready), 0);
    @(posedge clk); #1;
    chk("ready_one_edge_after_release", 32'(bus1.word_ready), 1);
    chk("ready2_one_edge_after_release", 32'(bus2.word_ready), 1);

    // Vector table: bytes on the line must match the hand-listed byte order.
    for (int i = 0; i < 7; i++) begin
      put(1, vecs[i].word);
      wait_done(1, n, nb);
      chk("vec_duration", n, WORD1);
      chk("vec_byte_done_count", nb, 4);
      chk("vec_rx_present", 32'(rx_q.size()), 1);
      rx = (rx_q.size() != 0) ? rx_q.pop_front() : 32'hx;
      for (int j = 0; j < 4; j++) chk("vec_byte", 32'(rx[8*j +: 8]), 32'(vecs[i].b[j]));
    end

    // Back-to-back with valid held: one idle-high cycle between words.
    exp_q.push_back(32'h00812e23);
    bus1.word_data  = 32'h00812e23;
    bus1.word_valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(32'h02010413);
    bus1.word_data = 32'h02010413;
    wait_done(1, n, nb);
    bus1.word_valid = 1'b0;
    chk("b2b_first_duration", n, WORD1);
    wait_done(1, n, nb);
    chk("b2b_second_duration", n, WORD1);
    chk("b2b_gap_cycles", gap, 1);
    chk("b2b_rx_count", 32'(rx_q.size()), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_word0", rx_q.pop_front(), 32'h00812e23);
      chk("b2b_word1", rx_q.pop_front(), 32'h02010413);
    end

    // Inputs wiggling mid-word must not disturb the line or cause a second acceptance.
    put(1, 32'h13579bdf);
    for (int c = 0; c < 300; c++) begin
      bus1.word_data  = $urandom;
      bus1.word_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus1.word_valid = 1'b0;
    wait_done(1, n, nb);
    chk("ignored_inputs_duration", n, WORD1 - 300);
    rx = (rx_q.size() != 0) ? rx_q.pop_front() : 32'hx;
    chk("ignored_inputs_word", rx, 32'h13579bdf);

    // Reset during byte 2, bit 3 (a zero bit, so the async rise is visible).
    put(1, 32'h5a00c3e1);
    repeat (243) @(posedge clk);
    #1;
    chk("pre_reset_line_low", 32'(txd1), 32'(line_bit(32'h5a00c3e1, 244, S1)));
    rst = 1'b1;
    #1;
    chk("async_reset_txd", 32'(txd1), 1);
    chk("async_reset_busy", 32'(busy1), 0);
    chk("async_reset_ready", 32'(bus1.word_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("aborted_word_not_reported", 32'(rx_q.size()), 0);
    put(1, 32'hffd00793);
    wait_done(1, n, nb);
    chk("post_reset_duration", n, WORD1);
    rx = (rx_q.size() != 0) ? rx_q.pop_front() : 32'hx;
    chk("post_reset_b0", 32'(rx[7:0]), 32'h93);
    chk("post_reset_b1", 32'(rx[15:8]), 32'h07);
    chk("post_reset_b2", 32'(rx[23:16]), 32'hd0);
    chk("post_reset_b3", 32'(rx[31:24]), 32'hff);

    // Random words with random idle gaps against the reference monitor.
    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      w = $urandom;
      put(1, w);
      wait_done(1, n, nb);
      chk("rand_duration", n, WORD1);
      rx = (rx_q.size() != 0) ? rx_q.pop_front() : 32'hx;
      chk("rand_word", rx, w);
    end

    // Two stop bits, decoded by the free-running receiver.
    put(2, 32'h00000000);
    wait_done(2, n, nb);
    chk("lb_duration_zeros", n, WORD2);
    chk("lb_byte_done_count", nb, 4);
    put(2, 32'hffffffff);
    wait_done(2, n, nb);
    chk("lb_duration_ones", n, WORD2);
    for (int r = 0; r < 4; r++) begin
      put(2, $urandom);
      wait_done(2, n, nb);
      chk("lb_rand_duration", n, WORD2);
    end
    repeat (20) @(posedge clk);
    #1;
    chk("lb_byte_count", 32'(rx2_q.size()), 32'(exp2_q.size()));
    while (rx2_q.size() != 0 && exp2_q.size() != 0)
      chk("lb_byte", 32'(rx2_q.pop_front()), 32'(exp2_q.pop_front()));
    chk("lb_framing_errs", frame_err2, 0);

    chk("stray_done_pulses", stray, 0);
    chk("reset_state_errs", rst_errs, 0);
    chk("expected_queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

UART transmitter that serialises 32-bit words onto a single TX line as four 8N1 bytes, least-significant byte first. This is the same byte order the instruction loader's UART receiver expects. It sits beside the UART receiver in the wrapper and drives the return path: memory readback, status words, and self-test loopback into the receiver. A valid/ready handshake on the word side lets an upstream FSM or FIFO stream words without knowing bit timing.

## Interface
Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz
- BIT_RATE, 9600, line bit rate in bits/s
- STOP_BITS, 1, stop bits per byte (1 or 2)
- Derived: CYCLES_PER_BIT = CLK_HZ / BIT_RATE, integer truncation; 5208 at defaults. Counter width = clog2(CYCLES_PER_BIT).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- word_valid  in  1  upstream has a word to send
- word_data  in  32  word to send; sampled only on acceptance
- word_ready  out  1  block can accept a word this cycle
- uart_txd  out  1  serial line, idle high, registered
- uart_tx_busy  out  1  a word is in flight
- byte_done  out  1  one-cycle pulse at the end of each byte's last stop bit
- word_done  out  1  one-cycle pulse at the end of the 4th byte's last stop bit

## Operation
- Acceptance happens on a rising edge with word_valid && word_ready. On acceptance:
  - latch word_data into a 32-bit shift/hold register
  - byte_idx <= 0
  - state <= START
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_txd=1, word_ready=1, busy=0.
  - START: uart_txd=0 for CYCLES_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: uart_txd = current byte bit[bit_idx], LSB first. Each bit is held CYCLES_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: uart_txd=1 for STOP_BITS*CYCLES_PER_BIT cycles. At the end, pulse byte_done.
    - If byte_idx<3: byte_idx+1, go to START. There is no idle gap between bytes.
    - Otherwise: also pulse word_done and go to IDLE.
- Byte n is word[8n+7:8n].
- word_ready is 0 in every state except IDLE. word_valid while not ready is ignored. word_data changes mid-word do not affect the line.
- uart_tx_busy = (state != IDLE).
- rst asserted at any time, including mid-bit:
  - uart_txd=1 immediately (asynchronous)
  - state IDLE, all counters cleared
  - byte_done and word_done low
  - the partial word is discarded; no done pulse is emitted for it

## Timing
- Reset values:
  - uart_txd=1
  - word_ready=0
  - uart_tx_busy=0
  - byte_done=0
  - word_done=0
- word_ready is registered. It rises on the first rising edge after rst deasserts, and again on the edge that ends the final stop bit.
- Latency: uart_txd falls (start bit) on the same edge that accepts the word, because the output is registered from the next-state value.
- Each byte lasts exactly (9+STOP_BITS)*CYCLES_PER_BIT cycles. A full word lasts 4*(9+STOP_BITS)*CYCLES_PER_BIT cycles from the acceptance edge to the word_done edge. At defaults this is 208320 cycles.
- byte_done and word_done are registered and high for exactly one cycle. They coincide for byte 3.
- Back-to-back words: word_ready is high for at least 1 cycle after word_done. If word_valid is held, the next word is accepted on the edge after word_done, giving exactly one idle-high cycle between words.
- The bit counter wraps at CYCLES_PER_BIT-1. There is no fractional-rate correction; the drift from truncation is accepted.

## Test plan
- Reset: hold rst for 10 cycles with word_valid=1.
  - During rst: uart_txd=1, word_ready=0, busy=0, no acceptance.
  - word_ready=1 one edge after release.
- Single word (CLK_HZ=1000, BIT_RATE=100, so 10 cycles/bit): send 32'hfe010113.
  - Line, sampled mid-bit, carries bytes 13, 01, 01, fe, each framed 0…1.
  - byte_done pulses at cycles 100, 200, 300, 400 after acceptance.
  - word_done pulses at 400.
- Back-to-back: hold word_valid with 32'h00812e23, then 32'h02010413.
  - Exactly one idle-high cycle separates the two words.
  - Bytes appear in order 23, 2e, 81, 00, 13, 04, 01, 02.
- Ignored inputs: toggle word_data and pulse word_valid during a word.
  - The line carries only the latched word.
  - No second acceptance occurs until word_done.
- Reset mid-frame: assert rst during byte 2, bit 3.
  - uart_txd=1 immediately; no word_done.
  - A following 32'hffd00793 transmits cleanly as 93, 07, d0, ff.
- Loopback at default parameters: drive uart_txd into the existing UART receiver with 32'h00000000 and then 32'hffffffff.
  - The receiver reports 8 valid bytes with matching values.
  - STOP_BITS=2 still decodes correctly.
